// File: rtl/enfreq_sched.sv
// Multi-channel clock-enable scheduler: one shared prescaler produces base_tick,
// and each channel divides it into its own single-cycle tick_en, optionally for a fixed burst.
`timescale 1ns/1ps
module enfreq_sched #(
  parameter int unsigned CH_NUM  = 4,
  parameter int unsigned PRE_MAX = 19,
  parameter int unsigned DIV_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_cnt,
  input  logic [CH_NUM-1:0] start,
  input  logic [CH_NUM-1:0] stop,
  output logic              base_tick,
  output logic [CH_NUM-1:0] tick_en,
  output logic [CH_NUM-1:0] run,
  output logic [CH_NUM-1:0] done,
  output logic              cfg_err
);

  localparam int unsigned PW = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  logic [PW-1:0]     pre_q, pre_d;
  logic              base_q, base_d;
  state_t            st_q   [CH_NUM];
  state_t            st_d   [CH_NUM];
  logic [DIV_W-1:0]  div_q  [CH_NUM];
  logic [DIV_W-1:0]  div_d  [CH_NUM];
  logic [DIV_W-1:0]  cnt_q  [CH_NUM];
  logic [DIV_W-1:0]  cnt_d  [CH_NUM];
  logic [DIV_W-1:0]  dcnt_q [CH_NUM];
  logic [DIV_W-1:0]  dcnt_d [CH_NUM];
  logic [DIV_W-1:0]  rem_q  [CH_NUM];
  logic [DIV_W-1:0]  rem_d  [CH_NUM];
  logic [CH_NUM-1:0] tick_q, tick_d;
  logic [CH_NUM-1:0] done_q, done_d;
  logic              err_q, err_d;
  logic              cfg_hit, cfg_busy;

  always_comb begin
    pre_d    = (pre_q == PW'(PRE_MAX)) ? '0 : pre_q + PW'(1);
    base_d   = (pre_q == PW'(PRE_MAX));
    tick_d   = '0;
    done_d   = '0;
    cfg_hit  = 1'b0;
    cfg_busy = 1'b0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      st_d[i]   = st_q[i];
      div_d[i]  = div_q[i];
      cnt_d[i]  = cnt_q[i];
      dcnt_d[i] = dcnt_q[i];
      rem_d[i]  = rem_q[i];

      if (cfg_ch == 2'(i)) begin
        cfg_hit = 1'b1;
        if (st_q[i] == S_RUN) cfg_busy = 1'b1;
      end

      case (st_q[i])
        S_RUN: begin
          // stop pre-empts a fire landing on the same base tick
          if (stop[i]) begin
            st_d[i] = S_IDLE;
          end else if (base_q) begin
            if (dcnt_q[i] == div_q[i]) begin
              dcnt_d[i] = '0;
              tick_d[i] = 1'b1;
              if (cnt_q[i] != '0) begin
                rem_d[i] = rem_q[i] - DIV_W'(1);
                if (rem_q[i] == DIV_W'(1)) begin
                  st_d[i]   = S_HOLD;
                  done_d[i] = 1'b1;
                end
              end
            end else begin
              dcnt_d[i] = dcnt_q[i] + DIV_W'(1);
            end
          end
        end
        default: begin
          if (stop[i]) begin
            st_d[i] = S_IDLE;
          end else if (start[i]) begin
            st_d[i]   = S_RUN;
            dcnt_d[i] = '0;
            rem_d[i]  = cnt_q[i];
          end
        end
      endcase

      if (cfg_we && (cfg_ch == 2'(i)) && (st_q[i] != S_RUN)) begin
        div_d[i] = cfg_div;
        cnt_d[i] = cfg_cnt;
      end
    end
    err_d = cfg_we && (!cfg_hit || cfg_busy);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q  <= '0;
      base_q <= 1'b0;
      tick_q <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        st_q[i]   <= S_IDLE;
        div_q[i]  <= '0;
        cnt_q[i]  <= '0;
        dcnt_q[i] <= '0;
        rem_q[i]  <= '0;
      end
    end else begin
      pre_q  <= pre_d;
      base_q <= base_d;
      tick_q <= tick_d;
      done_q <= done_d;
      err_q  <= err_d;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        st_q[i]   <= st_d[i];
        div_q[i]  <= div_d[i];
        cnt_q[i]  <= cnt_d[i];
        dcnt_q[i] <= dcnt_d[i];
        rem_q[i]  <= rem_d[i];
      end
    end
  end

  always_comb begin
    run = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      run[i] = (st_q[i] == S_RUN);
    end
  end

  assign base_tick = base_q;
  assign tick_en   = tick_q;
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_enfreq_sched.sv
// Scoreboard bench for enfreq_sched: expected pulses are derived from base-tick
// arithmetic at stimulus time and matched by a monitor against the DUT outputs.
`timescale 1ns/1ps
module tb_enfreq_sched;

  localparam int CH  = 3;
  localparam int PRE = 19;
  localparam int PER = PRE + 1;
  localparam int DW  = 8;
  localparam int INF = 1 << 30;
  localparam int LIM = 250;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [DW-1:0] cfg_div = '0;
  logic [DW-1:0] cfg_cnt = '0;
  logic [CH-1:0] start = '0;
  logic [CH-1:0] stop = '0;
  logic          base_tick;
  logic [CH-1:0] tick_en;
  logic [CH-1:0] run;
  logic [CH-1:0] done;
  logic          cfg_err;

  enfreq_sched #(.CH_NUM(CH), .PRE_MAX(PRE), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_cnt(cfg_cnt), .start(start), .stop(stop),
    .base_tick(base_tick), .tick_en(tick_en), .run(run), .done(done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // cycles elapsed since reset release (count of rising edges)
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int cyc;
    int ch;
    int kind;   // 0 tick_en, 1 done, 2 cfg_err
  } ev_t;

  ev_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  int  mdiv[CH], mcnt[CH], rfrom[CH], rto[CH];
  int  n1, b;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit running(input int c, input int n);
    return (rfrom[c] <= n - 1) && (n - 1 < rto[c]);
  endfunction

  function automatic void push(input int t, input int c, input int k);
    ev_t e;
    e.cyc = t; e.ch = c; e.kind = k;
    sbq.push_back(e);
  endfunction

  // start seen at edge n: base ticks in cycles >= n are counted; fire k lands on
  // counted tick k*(d+1) and tick_en appears the cycle after it.
  function automatic void schedule(input int c, input int n);
    int first, t, nk;
    first = ((n + PRE) / PER) * PER;
    nk = (mcnt[c] == 0) ? LIM : mcnt[c];
    rfrom[c] = n;
    rto[c] = INF;
    for (int k = 1; k <= nk; k++) begin
      t = first + PER * (k * (mdiv[c] + 1) - 1) + 1;
      push(t, c, 0);
      if (mcnt[c] != 0 && k == nk) begin
        push(t, c, 1);
        rto[c] = t;
      end
    end
  endfunction

  function automatic void model_clear();
    sbq.delete();
    for (int c = 0; c < CH; c++) begin
      mdiv[c] = 0; mcnt[c] = 0; rfrom[c] = 0; rto[c] = 0;
    end
  endfunction

  task automatic drv(input bit we, input int ch, input int dv, input int cn,
                     input logic [CH-1:0] st, input logic [CH-1:0] sp);
    int n;
    bit rf[CH];
    n = cyc + 1;
    cfg_we = we; cfg_ch = 2'(ch); cfg_div = DW'(dv); cfg_cnt = DW'(cn);
    start = st; stop = sp;
    for (int c = 0; c < CH; c++) rf[c] = running(c, n);
    for (int c = 0; c < CH; c++) begin
      if (sp[c] && rf[c]) begin
        for (int i = sbq.size() - 1; i >= 0; i--)
          if (sbq[i].ch == c && sbq[i].kind != 2 && sbq[i].cyc >= n) sbq.delete(i);
        rto[c] = n;
      end
    end
    for (int c = 0; c < CH; c++)
      if (st[c] && !sp[c] && !rf[c]) schedule(c, n);
    if (we) begin
      if (ch >= CH || rf[ch]) push(n, 0, 2);
      else begin
        mdiv[ch] = dv;
        mcnt[ch] = cn;
      end
    end
    @(negedge clk);
    cfg_we = 1'b0; start = '0; stop = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc + 1 < target) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    cfg_we = 1'b0; start = '0; stop = '0;
    #1;
    chk("rst_base_tick", base_tick, 0);
    chk("rst_tick_en", tick_en, 0);
    chk("rst_run", run, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  logic [CH-1:0] m_et, m_ed, m_er;
  logic          m_ee, m_bt;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      m_et = '0; m_ed = '0; m_ee = 1'b0; m_er = '0;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc) begin
          case (sbq[i].kind)
            0:       m_et[sbq[i].ch] = 1'b1;
            1:       m_ed[sbq[i].ch] = 1'b1;
            default: m_ee = 1'b1;
          endcase
          sbq.delete(i);
        end else if (sbq[i].cyc < cyc) begin
          chk("missed_event_cycle", cyc, sbq[i].cyc);
          sbq.delete(i);
        end
      end
      for (int c = 0; c < CH; c++) m_er[c] = (cyc >= rfrom[c]) && (cyc < rto[c]);
      m_bt = (cyc > 0) && (cyc % PER == 0);
      if (base_tick || m_bt)   chk("base_tick", base_tick, m_bt);
      if (tick_en != 0 || m_et != 0) chk("tick_en", tick_en, m_et);
      if (done != 0 || m_ed != 0)    chk("done", done, m_ed);
      if (cfg_err || m_ee)     chk("cfg_err", cfg_err, m_ee);
      if (run != 0 || m_er != 0)     chk("run", run, m_er);
    end
  end

  initial begin
    #1;
    do_reset();
    idle(65);

    drv(1, 0, 2, 3, '0, '0);
    drv(0, 0, 0, 0, 3'b001, '0);
    idle(200);

    drv(1, 1, 0, 0, '0, '0);
    n1 = cyc + 1;
    drv(0, 0, 0, 0, 3'b010, '0);
    b = ((n1 + PRE) / PER) * PER;
    wait_until(b + 50);
    drv(1, 1, 5, 5, '0, '0);
    wait_until(b + 90);
    drv(0, 0, 0, 0, '0, 3'b010);
    idle(60);

    drv(1, 3, 1, 1, '0, '0);
    drv(0, 0, 0, 0, 3'b100, 3'b100);
    idle(30);

    drv(1, 0, 1, 2, '0, '0);
    drv(1, 2, 1, 2, '0, '0);
    drv(0, 0, 0, 0, 3'b101, '0);
    idle(140);

    while (cyc % PER != 0) @(negedge clk);
    drv(0, 0, 0, 0, 3'b001, '0);
    idle(120);

    drv(1, 0, 0, 5, '0, '0);
    n1 = cyc + 1;
    drv(0, 0, 0, 0, 3'b001, '0);
    b = ((n1 + PRE) / PER) * PER;
    wait_until(b + 30);
    do_reset();
    drv(1, 0, 0, 5, '0, '0);
    drv(0, 0, 0, 0, 3'b001, '0);
    idle(150);

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 3))
        0: drv(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 4)), '0, '0);
        1: drv(0, 0, 0, 0, CH'($urandom_range(1, 7)), '0);
        2: drv(0, 0, 0, 0, '0, CH'($urandom_range(0, 7)) & CH'($urandom_range(0, 7)));
        default: drv(0, 0, 0, 0, CH'($urandom_range(0, 7)), CH'($urandom_range(0, 7)));
      endcase
      idle(int'($urandom_range(0, 20)));
    end

    drv(0, 0, 0, 0, '0, '1);
    idle(60);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enfreq_sched.md
Name: enfreq_sched

Overview:
- Multi-channel clock-enable scheduler built on one shared 1-of-(PRE_MAX+1) prescaler.
- Gives each of CH_NUM downstream counters its own single-cycle enable pulse, at a programmable ratio, optionally for a fixed burst length.
- All consumers stay on the single system clock; no derived clocks.
- Sits between the control logic and the enable-driven counters; the control logic issues config, start and stop.

Parameters:
- CH_NUM, 4, number of enable channels (cfg_ch width fixed at 2 bits; CH_NUM ≤ 4).
- PRE_MAX, 19, prescaler terminal count; base tick period = PRE_MAX+1 clk cycles.
- DIV_W, 8, width of per-channel divisor and burst count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  2  channel index for config write.
- cfg_div  in  DIV_W  divisor d; channel fires every d+1 base ticks.
- cfg_cnt  in  DIV_W  burst length; 0 = continuous.
- start  in  CH_NUM  per-channel start request, 1-cycle pulse.
- stop  in  CH_NUM  per-channel stop request, 1-cycle pulse.
- base_tick  out  1  prescaler pulse, 1 cycle wide.
- tick_en  out  CH_NUM  per-channel enable pulse, 1 cycle wide.
- run  out  CH_NUM  channel in RUN state (level).
- done  out  CH_NUM  burst complete, 1-cycle pulse.
- cfg_err  out  1  config write rejected, 1-cycle pulse.

Behaviour:
- Reset (rst low, async): prescaler=0, all channel counters=0, div_reg=0, cnt_reg=0, all channels IDLE, every output 0.
- Prescaler: free-running 0..PRE_MAX, wraps to 0. base_tick is registered; high for the one cycle after the prescaler holds PRE_MAX. First base_tick occurs PRE_MAX+1 cycles after reset release, then every PRE_MAX+1 cycles.
- Config write:
  - Applies when cfg_we=1, cfg_ch<CH_NUM and the target channel is not RUN. Next edge loads div_reg=cfg_div and cnt_reg=cfg_cnt.
  - Write to a RUN channel, or cfg_ch≥CH_NUM: ignored, cfg_err=1 next cycle.
- Per-channel FSM, states IDLE, RUN, HOLD:
  - IDLE/HOLD + start → RUN: dcnt=0, rem=cnt_reg. run rises next cycle.
  - RUN + stop → IDLE: no tick_en or done that cycle. stop beats start in the same cycle. stop in IDLE/HOLD → IDLE, no other effect.
  - RUN + start (no stop): ignored, no restart.
  - In RUN on each base_tick:
    - dcnt≠div_reg: dcnt+1.
    - dcnt==div_reg (fire): dcnt=0, tick_en=1 next cycle.
    - If cnt_reg≠0, rem decrements on fire. When rem==1 at fire: → HOLD, done=1 in the same cycle as the final tick_en, run falls.
  - cnt_reg=0: fires indefinitely until stop.
- Timing: with d=div_reg, the first tick_en comes (d+1) base ticks after start. Partial prescaler phase at start is not compensated; channels share base tick phase.
- Multiple channels may fire in the same cycle; tick_en bits are independent. No arbitration needed.
- div_reg=0: channel fires on every base_tick.
- start arriving the same cycle as base_tick: that base_tick is not counted.
- Reset mid-burst: channel to IDLE; rem, dcnt and registers cleared.

Test Plan:
- Reset release, no activity → base_tick at cycles 20, 40, 60 (PRE_MAX=19); tick_en, run, done stay 0.
- cfg ch0 d=2 cnt=3, start[0] → run[0]=1; tick_en[0] 3 pulses 60 cycles apart; done[0] coincides with 3rd pulse; run[0]=0 after.
- cfg ch1 d=0 cnt=0, start[1]; stop[1] after 5 ticks → exactly 5 tick_en[1] pulses one base tick apart; none after stop; done[1] never.
- ch1 running, cfg_we to ch1 → cfg_err pulse; div unchanged (tick spacing still 20). cfg_ch=3 with CH_NUM=3 → cfg_err.
- start[2] and stop[2] same cycle on IDLE ch2 → stays IDLE. ch0 and ch2 both d=1 started together → simultaneous tick_en[0] and tick_en[2].
- rst low mid-burst on ch0 (cnt=5, after 2 ticks) → all outputs 0 immediately. Re-config and restart yields full 5-tick burst.
